// File: rtl/spi_target_regfile_if.sv
// Serial link between SPI_Controller (master) and spi_target_regfile (slave).
// SCLK/SEN/MOSI are driven from the system clock domain.
interface spi_target_regfile_if;
  logic i_SCLK;
  logic i_SEN;
  logic i_MOSI;
  logic o_MISO;

  modport master (output i_SCLK, output i_SEN, output i_MOSI, input o_MISO);
  modport slave  (input i_SCLK, input i_SEN, input i_MOSI, output o_MISO);
endinterface

// File: rtl/spi_target_regfile.sv
// SPI target terminating the command/data frame protocol into a 64 x 20-bit register file.
// Optional read-only ID register at the top address: define SPI_TARGET_ID_REG_EN.
module spi_target_regfile #(
  parameter int unsigned       ADDR_W    = 6,
  parameter int unsigned       DATA_W    = 20,
  parameter logic [DATA_W-1:0] RESET_VAL = {DATA_W{1'b0}},
  parameter logic [DATA_W-1:0] ID_VALUE  = 20'hA201D
) (
  input  logic                 i_clk_sys,
  input  logic                 i_rst_n,
  spi_target_regfile_if.slave  spi,
  output logic                 o_wr_strobe,
  output logic [ADDR_W-1:0]    o_wr_addr,
  output logic [DATA_W-1:0]    o_wr_data,
  input  logic [ADDR_W-1:0]    i_dbg_addr,
  output logic [DATA_W-1:0]    o_dbg_data,
  output logic                 o_busy
);

`ifdef SPI_TARGET_ID_REG_EN
  localparam logic ID_EN = 1'b1;
`else
  localparam logic ID_EN = 1'b0;
`endif

  localparam int unsigned CMD_W = ADDR_W + 1;
  localparam int unsigned DEPTH = 1 << ADDR_W;
  localparam int unsigned CNT_W = $clog2(((DATA_W > CMD_W) ? DATA_W : CMD_W) + 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0] CMD_LAST  = CNT_W'(CMD_W - 1);
  localparam logic [CNT_W-1:0] DATA_DONE = CNT_W'(DATA_W);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    CMD      = 3'd1,
    WDATA    = 3'd2,
    WAIT_END = 3'd3,
    RGAP     = 3'd4,
    RDATA    = 3'd5
  } state_e;

  state_e            state_q;
  logic              sclk_q;
  logic              sen_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [CMD_W-1:0]  cmd_q;
  logic [DATA_W-1:0] shift_q;
  logic              miso_q;
  logic              wr_strobe_q;
  logic [ADDR_W-1:0] wr_addr_q;
  logic [DATA_W-1:0] wr_data_q;
  logic [DATA_W-1:0] mem_q [DEPTH];

  logic              rise_s;
  logic              sen_fall_s;
  logic              sen_rise_s;
  logic [CMD_W-1:0]  cmd_d;
  logic [DATA_W-1:0] rd_val_s;

  function automatic logic is_id(input logic [ADDR_W-1:0] addr);
    return ID_EN && (addr == {ADDR_W{1'b1}});
  endfunction

  assign rise_s     = spi.i_SCLK & ~sclk_q;
  assign sen_fall_s = ~spi.i_SEN & sen_q;
  assign sen_rise_s = spi.i_SEN & ~sen_q;
  assign cmd_d      = {cmd_q[CMD_W-2:0], spi.i_MOSI};

  // Read value for the address completed by the current command bit
  always_comb begin
    rd_val_s = mem_q[cmd_d[ADDR_W-1:0]];
    if (is_id(cmd_d[ADDR_W-1:0])) begin
      rd_val_s = ID_VALUE;
    end else begin
      rd_val_s = mem_q[cmd_d[ADDR_W-1:0]];
    end
  end

  // Local debug port reads the array directly
  always_comb begin
    o_dbg_data = mem_q[i_dbg_addr];
    if (is_id(i_dbg_addr)) begin
      o_dbg_data = ID_VALUE;
    end else begin
      o_dbg_data = mem_q[i_dbg_addr];
    end
  end

  // Frame FSM, shifters, write commit and register file
  always_ff @(posedge i_clk_sys or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q     <= IDLE;
      sclk_q      <= 1'b0;
      sen_q       <= 1'b1;
      cnt_q       <= {CNT_W{1'b0}};
      cmd_q       <= {CMD_W{1'b0}};
      shift_q     <= {DATA_W{1'b0}};
      miso_q      <= 1'b0;
      wr_strobe_q <= 1'b0;
      wr_addr_q   <= {ADDR_W{1'b0}};
      wr_data_q   <= {DATA_W{1'b0}};
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_q[i] <= RESET_VAL;
      end
    end else begin
      sclk_q      <= spi.i_SCLK;
      sen_q       <= spi.i_SEN;
      wr_strobe_q <= 1'b0;
      case (state_q)
        IDLE: begin
          miso_q <= 1'b0;
          cnt_q  <= {CNT_W{1'b0}};
          if (sen_fall_s) state_q <= CMD;
        end
        CMD: begin
          if (sen_rise_s) begin
            state_q <= IDLE;
            miso_q  <= 1'b0;
          end else if (rise_s) begin
            cmd_q <= cmd_d;
            cnt_q <= cnt_q + CNT_ONE;
            if (cnt_q == CMD_LAST) begin
              cnt_q <= {CNT_W{1'b0}};
              if (cmd_d[CMD_W-1]) begin
                state_q <= RGAP;
                shift_q <= rd_val_s;
                miso_q  <= rd_val_s[DATA_W-1];
              end else begin
                state_q <= WDATA;
              end
            end
          end
        end
        WDATA: begin
          // Commit one cycle after the last data bit has been shifted in
          if (cnt_q == DATA_DONE) begin
            if (!is_id(cmd_q[ADDR_W-1:0])) begin
              mem_q[cmd_q[ADDR_W-1:0]] <= shift_q;
              wr_strobe_q <= 1'b1;
              wr_addr_q   <= cmd_q[ADDR_W-1:0];
              wr_data_q   <= shift_q;
            end
            state_q <= sen_rise_s ? IDLE : WAIT_END;
          end else if (sen_rise_s) begin
            state_q <= IDLE;
            miso_q  <= 1'b0;
          end else if (rise_s) begin
            shift_q <= {shift_q[DATA_W-2:0], spi.i_MOSI};
            cnt_q   <= cnt_q + CNT_ONE;
          end
        end
        WAIT_END: begin
          if (sen_rise_s) begin
            state_q <= IDLE;
            miso_q  <= 1'b0;
          end
        end
        RGAP: begin
          // SEN was low on entry, so a falling edge here implies the gap was seen
          if (sen_fall_s) state_q <= RDATA;
        end
        RDATA: begin
          if (sen_rise_s) begin
            state_q <= IDLE;
            miso_q  <= 1'b0;
          end else if (rise_s) begin
            shift_q <= {shift_q[DATA_W-2:0], 1'b0};
            miso_q  <= shift_q[DATA_W-2];
          end
        end
        default: begin
          state_q <= IDLE;
          miso_q  <= 1'b0;
        end
      endcase
    end
  end

  assign spi.o_MISO  = miso_q;
  assign o_wr_strobe = wr_strobe_q;
  assign o_wr_addr   = wr_addr_q;
  assign o_wr_data   = wr_data_q;
  assign o_busy      = (state_q != IDLE);

endmodule

// File: tb/tb_spi_target_regfile.sv
// Directed self-checking bench for spi_target_regfile; acts as the SPI controller.
module tb_spi_target_regfile;
  logic        clk;
  logic        rst_n;
  logic        wr_strobe;
  logic [5:0]  wr_addr;
  logic [19:0] wr_data;
  logic [5:0]  dbg_addr;
  logic [19:0] dbg_data;
  logic        busy;
  int          passed;
  int          total;
  int          strobe_cnt;

  spi_target_regfile_if spi_if();

  spi_target_regfile dut (
    .i_clk_sys   (clk),
    .i_rst_n     (rst_n),
    .spi         (spi_if.slave),
    .o_wr_strobe (wr_strobe),
    .o_wr_addr   (wr_addr),
    .o_wr_data   (wr_data),
    .i_dbg_addr  (dbg_addr),
    .o_dbg_data  (dbg_data),
    .o_busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial strobe_cnt = 0;
  always @(negedge clk) begin
    if (wr_strobe === 1'b1) strobe_cnt <= strobe_cnt + 1;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic pulse(input logic b, output logic m);
    @(negedge clk); spi_if.i_MOSI = b; spi_if.i_SCLK = 1'b0;
    @(negedge clk); m = spi_if.o_MISO; spi_if.i_SCLK = 1'b1;
    @(negedge clk);
    @(negedge clk); spi_if.i_SCLK = 1'b0;
  endtask

  task automatic set_sen(input logic v);
    @(negedge clk); spi_if.i_SEN = v;
    @(negedge clk);
  endtask

  task automatic send_cmd(input logic rw, input logic [5:0] a);
    logic m;
    pulse(rw, m);
    for (int i = 5; i >= 0; i--) pulse(a[i], m);
  endtask

  task automatic spi_write(input logic [5:0] a, input logic [19:0] d);
    logic m;
    set_sen(1'b0);
    send_cmd(1'b0, a);
    for (int i = 19; i >= 0; i--) pulse(d[i], m);
    @(negedge clk);
    set_sen(1'b1);
    @(negedge clk);
  endtask

  task automatic spi_read(input logic [5:0] a, output logic [19:0] d, output logic m_end);
    logic m;
    set_sen(1'b0);
    send_cmd(1'b1, a);
    set_sen(1'b1);
    repeat (2) @(negedge clk);
    set_sen(1'b0);
    for (int i = 19; i >= 0; i--) begin
      pulse(1'b0, m);
      d[i] = m;
    end
    repeat (2) @(negedge clk);
    m_end = spi_if.o_MISO;
    set_sen(1'b1);
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    spi_if.i_SCLK = 1'b0; spi_if.i_SEN = 1'b1; spi_if.i_MOSI = 1'b0;
    dbg_addr = 6'h05;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    total++; if (dbg_data !== 20'h00000) $display("FAIL reset_dbg: got %h want %h", dbg_data, 20'h00000); else passed++;
    total++; if (spi_if.o_MISO !== 1'b0) $display("FAIL reset_miso: got %b want 0", spi_if.o_MISO); else passed++;
    total++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else passed++;
    total++; if (wr_strobe !== 1'b0) $display("FAIL reset_strobe: got %b want 0", wr_strobe); else passed++;
    total++; if ({wr_addr, wr_data} !== 26'h0) $display("FAIL reset_wr: got %h/%h want 0/0", wr_addr, wr_data); else passed++;
  endtask

  task automatic test_write();
    logic [19:0] d;
    logic m;
    int s0;
    d = 20'h12345;
    dbg_addr = 6'h05;
    s0 = strobe_cnt;
    set_sen(1'b0);
    send_cmd(1'b0, 6'h05);
    total++; if (busy !== 1'b1) $display("FAIL write_busy: got %b want 1", busy); else passed++;
    for (int i = 19; i >= 1; i--) pulse(d[i], m);
    @(negedge clk); spi_if.i_MOSI = d[0];
    @(negedge clk); spi_if.i_SCLK = 1'b1;
    @(negedge clk);
    total++; if (dbg_data !== 20'h00000) $display("FAIL write_lat1: got %h want %h", dbg_data, 20'h00000); else passed++;
    @(negedge clk);
    total++; if (dbg_data !== 20'h12345) $display("FAIL write_lat2: got %h want %h", dbg_data, 20'h12345); else passed++;
    total++; if (wr_strobe !== 1'b1) $display("FAIL write_strobe_hi: got %b want 1", wr_strobe); else passed++;
    total++; if (wr_addr !== 6'h05) $display("FAIL write_addr: got %h want 05", wr_addr); else passed++;
    total++; if (wr_data !== 20'h12345) $display("FAIL write_data: got %h want 12345", wr_data); else passed++;
    spi_if.i_SCLK = 1'b0;
    @(negedge clk);
    total++; if (wr_strobe !== 1'b0) $display("FAIL write_strobe_lo: got %b want 0", wr_strobe); else passed++;
    set_sen(1'b1);
    @(negedge clk);
    total++; if (strobe_cnt - s0 !== 1) $display("FAIL write_strobe_cnt: got %0d want 1", strobe_cnt - s0); else passed++;
    total++; if (busy !== 1'b0) $display("FAIL write_idle: got %b want 0", busy); else passed++;
  endtask

  task automatic test_read();
    logic [19:0] d;
    logic m_end;
    spi_write(6'h0A, 20'hABCDE);
    spi_read(6'h0A, d, m_end);
    total++; if (d !== 20'hABCDE) $display("FAIL read_data: got %h want ABCDE", d); else passed++;
    total++; if (m_end !== 1'b0) $display("FAIL read_miso_end: got %b want 0", m_end); else passed++;
    total++; if (busy !== 1'b0) $display("FAIL read_idle: got %b want 0", busy); else passed++;
  endtask

  task automatic test_abort();
    logic m;
    int s0;
    s0 = strobe_cnt;
    dbg_addr = 6'h05;
    set_sen(1'b0);
    send_cmd(1'b0, 6'h05);
    for (int i = 0; i < 10; i++) pulse(1'b1, m);
    set_sen(1'b1);
    repeat (3) @(negedge clk);
    total++; if (strobe_cnt - s0 !== 0) $display("FAIL abort_strobe: got %0d want 0", strobe_cnt - s0); else passed++;
    total++; if (dbg_data !== 20'h12345) $display("FAIL abort_reg: got %h want 12345", dbg_data); else passed++;
    total++; if (busy !== 1'b0) $display("FAIL abort_idle: got %b want 0", busy); else passed++;
  endtask

  task automatic test_back_to_back();
    logic [19:0] d;
    logic m_end;
    int s0;
    s0 = strobe_cnt;
    spi_write(6'h00, 20'hFFFFF);
    spi_write(6'h3E, 20'h80001);
    total++; if (strobe_cnt - s0 !== 2) $display("FAIL b2b_strobes: got %0d want 2", strobe_cnt - s0); else passed++;
    spi_read(6'h00, d, m_end);
    total++; if (d !== 20'hFFFFF) $display("FAIL b2b_read00: got %h want FFFFF", d); else passed++;
    total++; if (m_end !== 1'b0) $display("FAIL b2b_miso_end: got %b want 0", m_end); else passed++;
    spi_read(6'h3E, d, m_end);
    total++; if (d !== 20'h80001) $display("FAIL b2b_read3e: got %h want 80001", d); else passed++;
  endtask

  task automatic test_reset_mid();
    logic m;
    int s0;
    set_sen(1'b0);
    send_cmd(1'b0, 6'h0A);
    for (int i = 0; i < 5; i++) pulse(1'b1, m);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    total++; if (busy !== 1'b0) $display("FAIL rstmid_busy: got %b want 0", busy); else passed++;
    dbg_addr = 6'h0A;
    #1;
    total++; if (dbg_data !== 20'h00000) $display("FAIL rstmid_reg0a: got %h want 00000", dbg_data); else passed++;
    dbg_addr = 6'h05;
    #1;
    total++; if (dbg_data !== 20'h00000) $display("FAIL rstmid_reg05: got %h want 00000", dbg_data); else passed++;
    spi_if.i_SEN = 1'b1; spi_if.i_SCLK = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    s0 = strobe_cnt;
    dbg_addr = 6'h01;
    spi_write(6'h01, 20'h5A5A5);
    total++; if (strobe_cnt - s0 !== 1) $display("FAIL rstmid_strobe: got %0d want 1", strobe_cnt - s0); else passed++;
    total++; if (wr_addr !== 6'h01) $display("FAIL rstmid_addr: got %h want 01", wr_addr); else passed++;
    total++; if (dbg_data !== 20'h5A5A5) $display("FAIL rstmid_reg01: got %h want 5A5A5", dbg_data); else passed++;
  endtask

  task automatic test_id_reg();
    logic [19:0] d;
    logic m_end;
    logic [19:0] exp_d;
    int exp_strobes;
    int s0;
`ifdef SPI_TARGET_ID_REG_EN
    exp_d = 20'hA201D;
    exp_strobes = 0;
`else
    exp_d = 20'h00001;
    exp_strobes = 1;
`endif
    s0 = strobe_cnt;
    dbg_addr = 6'h3F;
    spi_write(6'h3F, 20'h00001);
    total++; if (strobe_cnt - s0 !== exp_strobes) $display("FAIL id_strobe: got %0d want %0d", strobe_cnt - s0, exp_strobes); else passed++;
    spi_read(6'h3F, d, m_end);
    total++; if (d !== exp_d) $display("FAIL id_read: got %h want %h", d, exp_d); else passed++;
    total++; if (dbg_data !== exp_d) $display("FAIL id_dbg: got %h want %h", dbg_data, exp_d); else passed++;
  endtask

  initial begin
    passed = 0;
    total  = 0;
    test_reset();
    test_write();
    test_read();
    test_abort();
    test_back_to_back();
    test_reset_mid();
    test_id_reg();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/spi_target_regfile.md
Name: spi_target_regfile

Overview:
- SPI target (responder) for the 3-wire-plus-MISO register protocol driven by SPI_Controller.
- Terminates the serial link and holds a 64 x 20-bit register file.
- Used as the device model in system benches and as the on-chip stand-in for the jt201D register bank.
- SCLK/SEN/MOSI are generated from i_clk_sys, so they are treated as synchronous inputs: edge detect only, no synchronizers.

Parameters:
- ADDR_W, 6, address bits per frame.
- DATA_W, 20, data bits per frame / register width.
- RESET_VAL, 20'h00000, reset content of every register.
- ID_VALUE, 20'hA201D, value of the read-only ID register (optional feature only).

Ports:
- i_clk_sys  in  1  system clock.
- i_rst_n  in  1  reset.
- i_SCLK  in  1  serial clock from controller; idle low.
- i_SEN  in  1  serial enable, active low.
- i_MOSI  in  1  serial data in.
- o_MISO  out  1  serial data out.
- o_wr_strobe  out  1  one-cycle pulse when a write commits.
- o_wr_addr  out  ADDR_W  address of last committed write.
- o_wr_data  out  DATA_W  data of last committed write.
- i_dbg_addr  in  ADDR_W  local combinational read address.
- o_dbg_data  out  DATA_W  register file content at i_dbg_addr.
- o_busy  out  1  high whenever state != IDLE.

Interface decision (already decided): reset i_rst_n, asynchronous, active-low; clock i_clk_sys.

Behaviour:
- Edge detection: register sclk_d and sen_d each cycle.
  - rise = i_SCLK & ~sclk_d.
  - sen_fall = ~i_SEN & sen_d.
  - sen_rise = i_SEN & ~sen_d.
  - i_MOSI is sampled in the cycle rise is true.
- Frame format, sampled on SCLK rising edges, MSB first:
  - Bit 0: R/W (1 = read).
  - Next ADDR_W bits: address.
  - Write frames: DATA_W data bits follow.
  - Read frames: controller raises SEN after the command. On its next SEN low period, the target shifts DATA_W bits out on MISO.
- Reset values:
  - o_MISO=0, o_wr_strobe=0, o_wr_addr=0, o_wr_data=0, o_busy=0.
  - All registers = RESET_VAL, state = IDLE, sclk_d=0, sen_d=1.
- States:
  - IDLE: sen_fall -> CMD; bit counter cleared.
  - CMD: each rise shifts i_MOSI into a 7-bit command shifter and increments the counter.
    - After the 7th rise: R/W=0 -> WDATA.
    - After the 7th rise: R/W=1 -> RGAP. The shift register is loaded with reg[addr] and o_MISO is driven with bit DATA_W-1 on the next clock.
  - WDATA: each rise shifts in one data bit. On the 20th rise, the next clock does all of:
    - writes reg[addr];
    - pulses o_wr_strobe for 1 cycle;
    - updates o_wr_addr/o_wr_data;
    - moves to WAIT_END.
  - WAIT_END: any further rises are ignored; sen_rise -> IDLE.
  - RGAP: waits for sen_rise then sen_fall; rises in this state are ignored; sen_fall -> RDATA. o_MISO already holds the MSB, so the controller's first sample is correct.
  - RDATA: each rise shifts the register left, filling with 0, and o_MISO follows the new MSB one cycle later.
    - After 20 rises, o_MISO = 0.
    - sen_rise -> IDLE.
- Abort: sen_rise in CMD or WDATA before completion -> IDLE, with no write and no strobe.
- Simultaneous events:
  - sen_rise has priority over rise in the same cycle.
  - sen_fall in WAIT_END or RDATA without a prior sen_rise is impossible by protocol; if it occurs, it is ignored.
- Exits to IDLE: o_MISO returns to 0 on entry to IDLE.
- Reset mid-frame: immediate return to reset values; the register file is reinitialised to RESET_VAL.
- Latency:
  - Write commit is visible on o_dbg_data 2 cycles after the 20th data rise.
  - o_dbg_data is combinational from the array.

Optional Feature:
- Macro: SPI_TARGET_ID_REG_EN.
- Defined:
  - Address 6'h3F is a read-only ID register.
  - Reads return ID_VALUE.
  - Writes to 3F complete the frame normally but do not modify the array, and o_wr_strobe stays 0.
  - o_dbg_data at 3F returns ID_VALUE.
- Not defined: 3F is an ordinary read/write register.

Test Plan:
- Reset then i_dbg_addr=6'h05 -> o_dbg_data=RESET_VAL, o_MISO=0, o_busy=0.
- SPI_Controller write addr 6'h05 data 20'h12345 -> single o_wr_strobe, o_wr_addr=05, o_wr_data=12345, o_dbg_data(05)=12345.
- Write 6'h0A=20'hABCDE, then controller read 6'h0A -> controller o_read_data=20'hABCDE; o_MISO=0 after the 20th rise.
- Write frame aborted by SEN high after 10 data bits -> no strobe, reg unchanged, state IDLE.
- i_rst_n pulsed low mid-WDATA -> o_busy=0, all regs RESET_VAL; next full write to 6'h01 succeeds.
- With SPI_TARGET_ID_REG_EN: write 6'h3F=20'h00001, then read 3F -> no strobe, read returns 20'hA201D. Without the macro: strobe, read returns 20'h00001.
